// File: rtl/fpu_exc_status.sv
// FPU exception status block: sticky flags, last-cause registers and a small
// record FIFO of unmasked exceptional results that raises a level request.
module fpu_exc_status #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  input  logic [3:0]                   op_addr,
  input  logic [1:0]                   overflow,
  input  logic                         en_we,
  input  logic [2:0]                   en_wdata,
  input  logic                         flag_clr,
  input  logic                         rec_pop,
  output logic [2:0]                   sticky,
  output logic [1:0]                   cause,
  output logic [3:0]                   cause_addr,
  output logic                         exc_req,
  output logic [3:0]                   rec_addr,
  output logic [1:0]                   rec_code,
  output logic [$clog2(DEPTH+1)-1:0]   rec_count,
  output logic [DROP_W-1:0]            drop_cnt,
  output logic [2:0]                   enable
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [2:0]        sticky_q, sticky_d;
  logic [1:0]        cause_q, cause_d;
  logic [3:0]        cause_addr_q, cause_addr_d;
  logic [2:0]        enable_q, enable_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              exc_req_q, exc_req_d;
  logic [5:0]        mem_q [DEPTH];

  logic              qual;
  logic [2:0]        code_onehot;
  logic              push_req;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic              drop;
  logic [DROP_W-1:0] drop_base;
  logic [5:0]        head;

  // Record queue handshake: the CPU sees a record whenever exc_req is high
  // (head valid) and consumes it with a one-cycle rec_pop. A pop with no
  // record present is ignored, except that a record pushed in the same cycle
  // is consumed straight through. A push meeting a full queue is only dropped
  // when no pop frees a slot in that cycle.
  always_comb begin
    qual        = op_valid && (op_addr != 4'd0);
    code_onehot = 3'b000;
    case (overflow)
      2'b01:   code_onehot = 3'b001;
      2'b10:   code_onehot = 3'b010;
      2'b11:   code_onehot = 3'b100;
      default: code_onehot = 3'b000;
    endcase
    push_req = qual && ((code_onehot & enable_q) != 3'b000);
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = rec_pop && (!empty || push_req);
    do_push  = push_req && (!full || rec_pop);
    drop     = push_req && full && !rec_pop;
  end

  always_comb begin
    sticky_d     = (flag_clr ? 3'b000 : sticky_q) | (qual ? code_onehot : 3'b000);
    cause_d      = qual ? overflow : cause_q;
    cause_addr_d = qual ? op_addr  : cause_addr_q;
    enable_d     = en_we ? en_wdata : enable_q;

    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);

    // A clear and a drop in the same cycle leave exactly one counted drop.
    drop_base = flag_clr ? '0 : drop_q;
    drop_d    = drop_base;
    if (drop && (drop_base != {DROP_W{1'b1}})) drop_d = drop_base + DROP_W'(1);

    exc_req_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sticky_q     <= '0;
      cause_q      <= '0;
      cause_addr_q <= '0;
      enable_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      exc_req_q    <= 1'b0;
    end else begin
      sticky_q     <= sticky_d;
      cause_q      <= cause_d;
      cause_addr_q <= cause_addr_d;
      enable_q     <= enable_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      exc_req_q    <= exc_req_d;
    end
  end

  // Storage needs no reset; an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {op_addr, overflow};
  end

  always_comb begin
    head     = empty ? 6'd0 : mem_q[rd_ptr_q];
    rec_addr = head[5:2];
    rec_code = head[1:0];
  end

  assign sticky     = sticky_q;
  assign cause      = cause_q;
  assign cause_addr = cause_addr_q;
  assign exc_req    = exc_req_q;
  assign rec_count  = count_q;
  assign drop_cnt   = drop_q;
  assign enable     = enable_q;

endmodule

// File: tb/tb_fpu_exc_status.sv
// Directed bench for fpu_exc_status: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_fpu_exc_status;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic [3:0] op_addr;
  logic [1:0] overflow;
  logic       en_we;
  logic [2:0] en_wdata;
  logic       flag_clr;
  logic       rec_pop;
  logic [2:0] sticky;
  logic [1:0] cause;
  logic [3:0] cause_addr;
  logic       exc_req;
  logic [3:0] rec_addr;
  logic [1:0] rec_code;
  logic [2:0] rec_count;
  logic [3:0] drop_cnt;
  logic [2:0] enable;

  int tests_run = 0;
  int tests_failed = 0;

  fpu_exc_status #(.DEPTH(4), .DROP_W(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_addr(op_addr), .overflow(overflow),
    .en_we(en_we), .en_wdata(en_wdata),
    .flag_clr(flag_clr), .rec_pop(rec_pop),
    .sticky(sticky), .cause(cause), .cause_addr(cause_addr),
    .exc_req(exc_req), .rec_addr(rec_addr), .rec_code(rec_code),
    .rec_count(rec_count), .drop_cnt(drop_cnt), .enable(enable)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op_valid = 1'b0; op_addr = 4'd0; overflow = 2'd0;
    en_we = 1'b0; en_wdata = 3'd0; flag_clr = 1'b0; rec_pop = 1'b0;
  endtask

  // one cycle of stimulus, then inputs return to idle
  task automatic drive(input logic v, input logic [3:0] a, input logic [1:0] c,
                       input logic pop, input logic clr);
    op_valid = v; op_addr = a; overflow = c; rec_pop = pop; flag_clr = clr;
    tick();
    idle();
  endtask

  task automatic op(input logic [3:0] a, input logic [1:0] c);
    drive(1'b1, a, c, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    drive(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic set_en(input logic [2:0] m);
    en_we = 1'b1; en_wdata = m;
    tick();
    idle();
  endtask

  task automatic chk_head(input string tag, input logic [3:0] a, input logic [1:0] c);
    chk({tag, "_addr"}, 32'(rec_addr), 32'(a));
    chk({tag, "_code"}, 32'(rec_code), 32'(c));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sticky"}, 32'(sticky), 32'd0);
    chk({tag, "_cause"}, 32'(cause), 32'd0);
    chk({tag, "_cause_addr"}, 32'(cause_addr), 32'd0);
    chk({tag, "_enable"}, 32'(enable), 32'd0);
    chk({tag, "_count"}, 32'(rec_count), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_exc_req"}, 32'(exc_req), 32'd0);
    chk_head(tag, 4'd0, 2'd0);
  endtask

  task automatic chk_first_op(input string tag);
    op(4'd1, 2'd1);
    chk({tag, "_sticky"}, 32'(sticky), 32'd1);
    chk({tag, "_cause"}, 32'(cause), 32'd1);
    chk({tag, "_cause_addr"}, 32'(cause_addr), 32'd1);
    chk({tag, "_count"}, 32'(rec_count), 32'd0);
    chk({tag, "_exc_req"}, 32'(exc_req), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk_reset_state("rst");

    // 1: op with everything masked only touches flags and cause
    chk_first_op("s1");

    // 2: three enabled exceptions queue in order
    set_en(3'b111);
    chk("s2_enable", 32'(enable), 32'd7);
    op(4'h5, 2'd1);
    chk("s2_exc_first", 32'(exc_req), 32'd1);
    chk("s2_count_first", 32'(rec_count), 32'd1);
    op(4'h7, 2'd2);
    op(4'h2, 2'd3);
    chk("s2_count", 32'(rec_count), 32'd3);
    chk("s2_exc", 32'(exc_req), 32'd1);
    chk("s2_sticky", 32'(sticky), 32'd7);
    chk_head("s2_h0", 4'h5, 2'd1);
    pop1();
    chk_head("s2_h1", 4'h7, 2'd2);
    pop1();
    chk_head("s2_h2", 4'h2, 2'd3);
    chk("s2_exc_last", 32'(exc_req), 32'd1);
    pop1();
    chk("s2_count_empty", 32'(rec_count), 32'd0);
    chk("s2_exc_empty", 32'(exc_req), 32'd0);
    chk_head("s2_empty", 4'd0, 2'd0);

    // 3: overflow-only mask, overfill then push+pop while full
    set_en(3'b001);
    for (int i = 1; i <= 6; i++) op(4'(i), 2'd1);
    chk("s3_count", 32'(rec_count), 32'd4);
    chk("s3_drop", 32'(drop_cnt), 32'd2);
    chk_head("s3_h0", 4'h1, 2'd1);
    drive(1'b1, 4'h9, 2'd1, 1'b1, 1'b0);
    chk("s3_pp_count", 32'(rec_count), 32'd4);
    chk("s3_pp_drop", 32'(drop_cnt), 32'd2);
    chk_head("s3_pp_head", 4'h2, 2'd1);
    op(4'hA, 2'd2);
    chk("s3_masked_drop", 32'(drop_cnt), 32'd2);
    chk("s3_masked_cause", 32'(cause), 32'd2);
    pop1(); chk_head("s3_d1", 4'h3, 2'd1);
    pop1(); chk_head("s3_d2", 4'h4, 2'd1);
    pop1(); chk_head("s3_d3", 4'h9, 2'd1);
    pop1();
    chk("s3_drained", 32'(rec_count), 32'd0);

    // 4: push+pop on empty passes through; pop on empty is ignored
    drive(1'b1, 4'hB, 2'd1, 1'b1, 1'b0);
    chk("s4_pp_count", 32'(rec_count), 32'd0);
    chk_head("s4_pp_head", 4'd0, 2'd0);
    chk("s4_pp_exc", 32'(exc_req), 32'd0);
    chk("s4_pp_cause_addr", 32'(cause_addr), 32'hB);
    pop1();
    chk("s4_pop_empty", 32'(rec_count), 32'd0);
    op(4'hC, 2'd1);
    chk("s4_after_count", 32'(rec_count), 32'd1);
    chk_head("s4_after_head", 4'hC, 2'd1);
    pop1();
    drive(1'b0, 4'd0, 2'd0, 1'b0, 1'b1);
    chk("s4_clr_sticky", 32'(sticky), 32'd0);
    op(4'h0, 2'd3);
    chk("s4_noop_sticky", 32'(sticky), 32'd0);
    chk("s4_noop_cause", 32'(cause), 32'd1);
    chk("s4_noop_cause_addr", 32'(cause_addr), 32'hC);
    chk("s4_noop_count", 32'(rec_count), 32'd0);

    // 5: flag_clr interactions and mask write racing an op
    for (int i = 1; i <= 5; i++) op(4'(i), 2'd1);
    chk("s5_drop_pre", 32'(drop_cnt), 32'd1);
    drive(1'b1, 4'h8, 2'd2, 1'b0, 1'b1);
    chk("s5_clr_sticky", 32'(sticky), 32'd2);
    chk("s5_clr_drop", 32'(drop_cnt), 32'd0);
    chk("s5_clr_count", 32'(rec_count), 32'd4);
    drive(1'b1, 4'hD, 2'd1, 1'b0, 1'b1);
    chk("s5_clr_drop_race", 32'(drop_cnt), 32'd1);
    chk("s5_clr_sticky_race", 32'(sticky), 32'd1);
    for (int i = 0; i < 4; i++) pop1();
    chk("s5_drained", 32'(rec_count), 32'd0);
    en_we = 1'b1; en_wdata = 3'b000;
    op(4'hE, 2'd1);
    chk("s5_we_count", 32'(rec_count), 32'd1);
    chk_head("s5_we_head", 4'hE, 2'd1);
    chk("s5_we_enable", 32'(enable), 32'd0);
    op(4'hF, 2'd1);
    chk("s5_masked_count", 32'(rec_count), 32'd1);

    // 6: reset discards pending records and flags
    set_en(3'b111);
    op(4'h3, 2'd2);
    op(4'h4, 2'd3);
    chk("s6_count_pre", 32'(rec_count), 32'd3);
    chk("s6_sticky_pre", 32'(sticky), 32'd7);
    rst = 1'b0;
    op(4'h6, 2'd3);
    rst = 1'b1;
    chk_reset_state("s6");
    chk_first_op("s6_first");

    // drop counter saturates at all-ones
    set_en(3'b001);
    for (int i = 0; i < 4 + 17; i++) op(4'h2, 2'd1);
    chk("sat_drop", 32'(drop_cnt), 32'd15);
    chk("sat_count", 32'(rec_count), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
